// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter: runs the HOLD/HLDA handshake toward the CPU and hands the
// local bus to one of NREQ secondary masters at a time. Priority rotates
// round-robin, and each tenure is limited to MAX_TENURE cycles.
// Optional macro BUS_HOLD_ARB_SYNC_EN: when defined, hlda passes through a
// two-flop synchronizer. When undefined, hlda is used directly.
module bus_hold_arbiter #(
  parameter int NREQ         = 2,
  parameter int MAX_TENURE   = 64,
  parameter int HLDA_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            hold,
  input  logic            hlda,
  output logic            bus_own,
  output logic [2:0]      owner,
  output logic            err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(MAX_TENURE + 1);
  localparam logic [TW:0] TENURE_LIM  = (TW+1)'(MAX_TENURE);
  localparam logic [8:0]  TIMEOUT_LIM = 9'(HLDA_TIMEOUT);

  typedef enum logic [1:0] {IDLE, HOLD_WAIT, GRANTED, RELEASE} state_t;

  state_t          state;
  logic [2:0]      sel;
  logic [2:0]      last_owner;
  logic [7:0]      wait_cnt;
  logic [TW-1:0]   tenure;
  logic            hlda_s;

  logic [3:0]      idle_pick;
  logic [3:0]      hand_pick;
  logic [NREQ-1:0] req_masked;
  logic [NREQ-1:0] gnt_sel;
  logic            req_sel;
  logic [8:0]      wait_inc;
  logic [TW:0]     tenure_inc;
  logic            wait_hit;
  logic            tenure_hit;

`ifdef BUS_HOLD_ARB_SYNC_EN
  logic hlda_meta;
  logic hlda_sync;

  // Two-flop synchronizer for the CPU's asynchronous acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      hlda_meta <= 1'b0;
      hlda_sync <= 1'b0;
    end else begin
      hlda_meta <= hlda;
      hlda_sync <= hlda_meta;
    end
  end

  assign hlda_s = hlda_sync;
`else
  assign hlda_s = hlda;
`endif

  // Round-robin search that starts just after 'last'.
  // Bit 3 of the result is "found", and bits 2:0 are the winner index.
  function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] last);
    logic [3:0] res;
    int         idx;
    res = '0;
    // Walk from the farthest candidate to the nearest, so the nearest pending one wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(last) + 1 + i) % NREQ;
      if (r[idx[IW-1:0]]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  // Arbitration candidates, current-selection decode and counter limit tests
  always_comb begin
    idle_pick  = rr_pick(req, last_owner);
    // A handoff never re-picks the outgoing owner, even if its req is still high
    req_masked = req;
    req_masked[sel[IW-1:0]] = 1'b0;
    hand_pick  = rr_pick(req_masked, sel);
    gnt_sel    = '0;
    gnt_sel[sel[IW-1:0]] = 1'b1;
    req_sel    = req[sel[IW-1:0]];
    wait_inc   = {1'b0, wait_cnt} + 9'd1;
    tenure_inc = {1'b0, tenure} + 1'b1;
    wait_hit   = (wait_inc >= TIMEOUT_LIM);
    tenure_hit = (tenure_inc >= TENURE_LIM);
  end

  // Main control FSM; all outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      hold       <= 1'b0;
      bus_own    <= 1'b0;
      owner      <= 3'(NREQ - 1);
      last_owner <= 3'(NREQ - 1);
      sel        <= 3'(NREQ - 1);
      wait_cnt   <= '0;
      tenure     <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_pick[3]) begin
            sel      <= idle_pick[2:0];
            hold     <= 1'b1;
            wait_cnt <= '0;
            tenure   <= '0;
            state    <= HOLD_WAIT;
          end
        end
        HOLD_WAIT: begin
          if (!req_sel) begin
            // Requester gave up before the CPU let go of the bus
            hold  <= 1'b0;
            state <= RELEASE;
          end else if (hlda_s) begin
            gnt     <= gnt_sel;
            bus_own <= 1'b1;
            owner   <= sel;
            tenure  <= '0;
            state   <= GRANTED;
          end else if (wait_hit) begin
            hold       <= 1'b0;
            err        <= 1'b1;
            last_owner <= sel;
            state      <= RELEASE;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        GRANTED: begin
          if (!hlda_s) begin
            // The CPU took the bus back under us. Release at once, and
            // rotate past this grantee.
            gnt        <= '0;
            bus_own    <= 1'b0;
            hold       <= 1'b0;
            err        <= 1'b1;
            last_owner <= sel;
            state      <= RELEASE;
          end else if (!req_sel || tenure_hit) begin
            gnt        <= '0;
            bus_own    <= 1'b0;
            last_owner <= sel;
            if (hand_pick[3]) begin
              // Keep HOLD up, and give the next grant after one dead cycle
              sel      <= hand_pick[2:0];
              wait_cnt <= '0;
              tenure   <= '0;
              state    <= HOLD_WAIT;
            end else begin
              hold  <= 1'b0;
              state <= RELEASE;
            end
          end else begin
            tenure <= tenure_inc[TW-1:0];
          end
        end
        RELEASE: begin
          hold <= 1'b0;
          if (!hlda_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed testbench for bus_hold_arbiter (default build, hlda used directly).
// A cycle model of the arbitration rules is checked against the DUT on every
// cycle. Literal expectations at key points pin the model.
module tb_bus_hold_arbiter;

  localparam int NREQ = 2;
  localparam int MAXT = 4;
  localparam int TOUT = 8;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            hold;
  logic            hlda;
  logic            bus_own;
  logic [2:0]      owner;
  logic            err;

  int tests_run;
  int tests_failed;

  bus_hold_arbiter #(.NREQ(NREQ), .MAX_TENURE(MAXT), .HLDA_TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .hold(hold),
    .hlda(hlda), .bus_own(bus_own), .owner(owner), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // This model does not use a state variable. The phase is implied by which
  // variables are set:
  //   m_gidx >= 0  -> bus granted
  //   m_cand >= 0  -> waiting for acknowledge
  //   m_drain      -> waiting for hlda to fall
  int m_gidx, m_cand, m_last, m_owner, m_waited, m_used;
  bit m_hold, m_err, m_drain, m_valid;

  function automatic int pick(input logic [NREQ-1:0] r, input int last, input int excl);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (idx != excl && r[idx[0:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_gidx = -1; m_cand = -1; m_last = NREQ - 1; m_owner = NREQ - 1;
    m_waited = 0; m_used = 0; m_hold = 0; m_err = 0; m_drain = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic h, input logic rs);
    int nxt;
    if (rs) begin
      model_reset();
      m_valid = 1;
      return;
    end
    m_err = 0;
    if (m_drain) begin
      if (!h) m_drain = 0;
    end else if (m_gidx >= 0) begin
      if (!h) begin
        m_last = m_gidx; m_gidx = -1; m_hold = 0; m_err = 1; m_drain = 1;
      end else begin
        m_used = m_used + 1;
        if (!r[m_gidx[0:0]] || m_used >= MAXT) begin
          m_last = m_gidx;
          nxt = pick(r, m_gidx, m_gidx);
          m_gidx = -1;
          if (nxt >= 0) begin
            m_cand = nxt; m_waited = 0;
          end else begin
            m_hold = 0; m_drain = 1;
          end
        end
      end
    end else if (m_cand >= 0) begin
      if (!r[m_cand[0:0]]) begin
        m_hold = 0; m_drain = 1; m_cand = -1;
      end else if (h) begin
        m_gidx = m_cand; m_owner = m_cand; m_used = 0; m_cand = -1;
      end else begin
        m_waited = m_waited + 1;
        if (m_waited >= TOUT) begin
          m_hold = 0; m_err = 1; m_last = m_cand; m_cand = -1; m_drain = 1;
        end
      end
    end else begin
      nxt = pick(r, m_last, -1);
      if (nxt >= 0) begin
        m_cand = nxt; m_hold = 1; m_waited = 0;
      end
    end
  endtask

  initial begin
    m_valid = 0;
    model_reset();
    forever begin
      @(posedge clk);
      model_step(req, hlda, rst);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        logic [NREQ-1:0] mg;
        mg = '0;
        if (m_gidx >= 0) mg[m_gidx[0:0]] = 1'b1;
        check("cyc_gnt",     8'(gnt),     8'(mg));
        check("cyc_hold",    8'(hold),    8'(m_hold));
        check("cyc_bus_own", 8'(bus_own), 8'(m_gidx >= 0));
        check("cyc_owner",   8'(owner),   8'(m_owner));
        check("cyc_err",     8'(err),     8'(m_err));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; req = '0; hlda = 1'b0;
    tick(2);
    rst = 1'b0;
    check("rst_gnt", 8'(gnt), 8'h00);
    check("rst_hold", 8'(hold), 8'h00);
    check("rst_owner", 8'(owner), 8'h01);
    check("rst_bus_own", 8'(bus_own), 8'h00);
    tick(1);

    // Round-robin with both requesters held, and tenure 4
    req = 2'b11; tick(1);
    check("rr_hold_up", 8'(hold), 8'h01);
    hlda = 1'b1; tick(1);
    check("rr_gnt0", 8'(gnt), 8'h01);
    tick(3);
    check("rr_gnt0_last", 8'(gnt), 8'h01);
    tick(1);
    check("rr_gap_gnt", 8'(gnt), 8'h00);
    check("rr_gap_hold", 8'(hold), 8'h01);
    check("rr_gap_bus_own", 8'(bus_own), 8'h00);
    tick(1);
    check("rr_gnt1", 8'(gnt), 8'h02);
    check("rr_owner1", 8'(owner), 8'h01);
    tick(4);
    check("rr_gap2_gnt", 8'(gnt), 8'h00);
    tick(1);
    check("rr_gnt0_again", 8'(gnt), 8'h01);
    req = 2'b00; tick(1);
    check("rr_end_gnt", 8'(gnt), 8'h00);
    check("rr_end_hold", 8'(hold), 8'h00);
    hlda = 1'b0; tick(2);

    // Single request, with hlda arriving a few cycles after hold
    req = 2'b01; tick(1);
    check("single_hold", 8'(hold), 8'h01);
    check("single_nognt", 8'(gnt), 8'h00);
    tick(2);
    hlda = 1'b1; tick(1);
    check("single_gnt", 8'(gnt), 8'h01);
    check("single_bus_own", 8'(bus_own), 8'h01);
    check("single_owner", 8'(owner), 8'h00);
    tick(1);
    req = 2'b00; tick(1);
    check("single_drop_gnt", 8'(gnt), 8'h00);
    check("single_drop_hold", 8'(hold), 8'h00);
    hlda = 1'b0; tick(2);

    // HLDA timeout: hold lasts exactly 8 cycles, then err pulses once
    req = 2'b01; tick(1);
    check("to_hold_up", 8'(hold), 8'h01);
    tick(7);
    check("to_hold_still", 8'(hold), 8'h01);
    check("to_no_err_yet", 8'(err), 8'h00);
    tick(1);
    check("to_hold_down", 8'(hold), 8'h00);
    check("to_err", 8'(err), 8'h01);
    check("to_nognt", 8'(gnt), 8'h00);
    req = 2'b00; tick(1);
    check("to_err_clear", 8'(err), 8'h00);
    tick(1);

    // Protocol violation: hlda drops while the bus is granted
    req = 2'b01; tick(1);
    hlda = 1'b1; tick(1);
    check("pv_gnt", 8'(gnt), 8'h01);
    hlda = 1'b0; tick(1);
    check("pv_gnt_drop", 8'(gnt), 8'h00);
    check("pv_err", 8'(err), 8'h01);
    check("pv_hold", 8'(hold), 8'h00);
    req = 2'b00; tick(1);
    check("pv_err_clear", 8'(err), 8'h00);
    tick(1);

    // Reset in the middle of a tenure
    req = 2'b01; tick(1);
    hlda = 1'b1; tick(2);
    check("mr_gnt", 8'(gnt), 8'h01);
    rst = 1'b1; tick(1);
    check("mr_gnt_rst", 8'(gnt), 8'h00);
    check("mr_hold_rst", 8'(hold), 8'h00);
    check("mr_owner_rst", 8'(owner), 8'h01);
    rst = 1'b0; req = 2'b10; hlda = 1'b0; tick(1);
    check("mr_hold_again", 8'(hold), 8'h01);
    hlda = 1'b1; tick(1);
    check("mr_gnt1", 8'(gnt), 8'h02);
    check("mr_owner1", 8'(owner), 8'h01);
    req = 2'b00; tick(1);
    check("mr_end_gnt", 8'(gnt), 8'h00);
    hlda = 1'b0; tick(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_hold_arbiter.md
# bus_hold_arbiter

Arbitrates ownership of the CPU's local bus between the processor and up to NREQ secondary masters, such as a UART loader DMA and a refresh engine. It runs the HOLD/HLDA handshake toward the CPU and issues one-hot grants to requesters. It rotates priority and enforces a bounded tenure. It sits beside bus_control and memory_control in the bridge and drives the `hold` pin that is currently tied to 0.

## Interface
- NREQ, 2: number of secondary requesters (1..8).
- MAX_TENURE, 64: maximum clock cycles a grant may be held before preemption (≥ 2).
- HLDA_TIMEOUT, 255: cycles to wait for HLDA after raising HOLD (≥ 4).

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester bus request, level, held high for the whole tenure.
- gnt  out  NREQ  one-hot grant; at most one bit is high.
- hold  out  1  HOLD request to the CPU.
- hlda  in  1  HOLD acknowledge from the CPU; asynchronous.
- bus_own  out  1  high while any gnt is high; tells the bridge data drivers the CPU is off the bus.
- owner  out  3  index of the current or last grantee.
- err  out  1  one-cycle pulse on HLDA timeout or HLDA protocol violation.

## Operation
- The FSM has four states: IDLE, HOLD_WAIT, GRANTED, RELEASE.
- Priority is round-robin:
  - the search starts at (last_owner+1) mod NREQ;
  - last_owner resets to NREQ-1, so req[0] wins first.
- IDLE:
  - if any req is high, latch the winner in `sel`, set hold=1, clear the tenure counter and go to HOLD_WAIT;
  - otherwise stay with hold=0.
- HOLD_WAIT:
  - when hlda_s=1, assert gnt[sel] and go to GRANTED;
  - if req[sel] drops first, go to RELEASE;
  - if the wait counter reaches HLDA_TIMEOUT, set hold=0, pulse err, set last_owner=sel and go to RELEASE.
- GRANTED:
  - the tenure counter increments each cycle;
  - the state exits when req[sel]=0 or tenure reaches MAX_TENURE. On exit, drop gnt and set last_owner=sel.
    - If another req is pending, go directly to HOLD_WAIT with the new `sel`. Hold stays high and the new gnt follows after one dead cycle (handoff).
    - Otherwise drop hold and go to RELEASE.
  - If hlda_s falls while in GRANTED, drop gnt immediately, pulse err and go to RELEASE.
- RELEASE:
  - hold=0;
  - stay until hlda_s=0, then go to IDLE. New requests wait.
- A preempted requester must drop req for at least one cycle before re-requesting.
  - A still-high req[sel] is ignored in the next arbitration round, because rotation has already moved past it.
- Reset values: gnt=0, hold=0, bus_own=0, owner=NREQ-1, err=0, state=IDLE, counters=0.
- Reset mid-tenure:
  - all outputs take their reset values on the next edge;
  - the CPU then sees HOLD fall and resumes.

## Timing
- A req sampled high in IDLE gives hold=1 at the next edge (1 cycle).
- HLDA high gives gnt 2 cycles later with the synchronizer, +1 for the FSM edge.
  - Total req→gnt is 1 + HLDA latency + 3 cycles.
- When req drops, gnt=0 at the next edge.
- Handoff gap is exactly one cycle with gnt=0. bus_own stays low during that cycle.
- Tenure: gnt is high for at most MAX_TENURE cycles.
- The timeout counter is 8 bits wide and saturates. The tenure counter is clog2(MAX_TENURE+1) bits wide.
- err is exactly one cycle wide.

## Configuration
- Macro: BUS_HOLD_ARB_SYNC_EN.
- Defined: hlda passes through a 2-flop synchronizer to form hlda_s (+2 cycles latency). Use this when the CPU clock is asynchronous to clk.
- Undefined: hlda_s = hlda directly (0 added latency). All other behaviour is identical.

## Test plan
- Single request:
  - stimulus: req=01, hlda rises 3 cycles after hold;
  - response: hold=1 at +1, gnt=01 at hlda+3 (SYNC_EN), bus_own=1;
  - then drop req: gnt=00 next cycle, hold=0, IDLE after hlda falls.
- Round-robin:
  - stimulus: req=11 held continuously, MAX_TENURE=4;
  - response: gnt sequence 01, (gap), 10, (gap), 01; each tenure is exactly 4 cycles; hold stays high throughout.
- HLDA timeout:
  - stimulus: req=01, hlda held 0, HLDA_TIMEOUT=8;
  - response: hold falls after 8 wait cycles, err pulses once, gnt never asserts.
- Protocol violation:
  - stimulus: in GRANTED, force hlda=0;
  - response: gnt=00 within 3 cycles (SYNC_EN), err=1 for 1 cycle, hold=0.
- Reset mid-tenure:
  - stimulus: rst=1 for one cycle during GRANTED;
  - response: next edge gives gnt=00, hold=0, owner=NREQ-1; then with req=10 and hlda returning, the first grant goes to req[1].
